// File: rtl/counter_chain_sequencer.sv
// counter_chain_sequencer: 74163-style cascaded nibble counters forming H/V video timing with start/stop FSM.
// Define COUNTER_SEQ_TRACE_EN to print a simulation message at every frame end.
module counter_chain_sequencer #(
    parameter int H_NIB        = 3,
    parameter int V_NIB        = 3,
    parameter int H_PRELOAD    = 'hE00,
    parameter int V_PRELOAD    = 'hEFA,
    parameter int HBLANK_START = 'hF00,
    parameter int HBLANK_END   = 'hE00,
    parameter int HSYNC_START  = 'hF20,
    parameter int HSYNC_END    = 'hF40,
    parameter int VBLANK_START = 'hFE0,
    parameter int VSYNC_START  = 'hFE8,
    parameter int VSYNC_END    = 'hFEC
) (
    input  logic             clk,
    input  logic             _reset,
    input  logic             ce,
    input  logic             start,
    input  logic             stop_req,
    output logic [4*H_NIB-1:0] hcount,
    output logic [4*V_NIB-1:0] vcount,
    output logic             h_rco,
    output logic             v_rco,
    output logic             hblank,
    output logic             vblank,
    output logic             _hsync,
    output logic             _vsync,
    output logic             frame_start,
    output logic             running,
    output logic             stopped
);
    localparam int H_W = 4 * H_NIB;
    localparam int V_W = 4 * V_NIB;
    localparam logic [H_W-1:0] HPRE = H_W'(H_PRELOAD);
    localparam logic [V_W-1:0] VPRE = V_W'(V_PRELOAD);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state_q, state_d;
    logic pend_q, pend_d;
    logic [H_W-1:0] hcount_q, hcount_d, hinc;
    logic [V_W-1:0] vcount_q, vcount_d, vinc;
    logic hblank_q, vblank_q, hsync_n_q, vsync_n_q;
    logic [H_NIB-1:0] hent;
    logic [V_NIB-1:0] vent;

    function automatic logic in_win(input int c, input int s, input int e);
        return (s <= e) ? (c >= s && c < e) : (c >= s || c < e);
    endfunction

    assign running     = (state_q == RUN);
    assign stopped     = (state_q == IDLE);
    assign h_rco       = running & (&hcount_q);
    assign v_rco       = h_rco & (&vcount_q);
    assign frame_start = running & (hcount_q == HPRE) & (vcount_q == VPRE);
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign _hsync      = hsync_n_q;
    assign _vsync      = vsync_n_q;

    // Each stage enables the next only while it sits at F, like ENT->RCO on a 74163.
    assign hent[0] = running;
    assign vent[0] = h_rco;
    for (genvar i = 0; i < H_NIB; i++) begin : g_h
        if (i < H_NIB - 1) begin : g_e
            assign hent[i+1] = hent[i] & (hcount_q[4*i+:4] == 4'hF);
        end
        assign hinc[4*i+:4] = hent[i] ? hcount_q[4*i+:4] + 4'd1 : hcount_q[4*i+:4];
    end
    for (genvar i = 0; i < V_NIB; i++) begin : g_v
        if (i < V_NIB - 1) begin : g_e
            assign vent[i+1] = vent[i] & (vcount_q[4*i+:4] == 4'hF);
        end
        assign vinc[4*i+:4] = vent[i] ? vcount_q[4*i+:4] + 4'd1 : vcount_q[4*i+:4];
    end

    assign hcount_d = (!running || h_rco) ? HPRE : hinc;
    assign vcount_d = (!running || v_rco) ? VPRE : vinc;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        if (state_q == IDLE) begin
            state_d = start ? RUN : IDLE;
        end else if (v_rco && (pend_q || stop_req)) begin
            state_d = IDLE;
            pend_d  = 1'b0;
        end else begin
            pend_d = pend_q | stop_req;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q   <= IDLE;
            pend_q    <= 1'b0;
            hcount_q  <= HPRE;
            vcount_q  <= VPRE;
            hblank_q  <= 1'b1;
            vblank_q  <= 1'b1;
            hsync_n_q <= 1'b1;
            vsync_n_q <= 1'b1;
        end else if (ce) begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
            hblank_q  <= in_win(int'(hcount_q), HBLANK_START, HBLANK_END);
            vblank_q  <= int'(vcount_q) >= VBLANK_START;
            hsync_n_q <= !in_win(int'(hcount_q), HSYNC_START, HSYNC_END);
            vsync_n_q <= !in_win(int'(vcount_q), VSYNC_START, VSYNC_END);
        end
    end

`ifdef COUNTER_SEQ_TRACE_EN
    always @(posedge clk) begin
        if (_reset && ce && v_rco)
            $display("counter_chain_sequencer - frame end vcount=%h stop=%b", vcount_q, pend_q | stop_req);
    end
`else
`endif
endmodule

// File: tb/tb_counter_chain_sequencer.sv
// tb_counter_chain_sequencer: directed checks of the timing chain, using a 40-line frame (V_PRELOAD=FD8) to keep runs short.
module tb_counter_chain_sequencer;
    logic clk = 1'b0, _reset = 1'b1, ce = 1'b1, start = 1'b0, stop_req = 1'b0;
    logic [11:0] hcount, vcount;
    logic h_rco, v_rco, hblank, vblank, _hsync, _vsync, frame_start, running, stopped;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    counter_chain_sequencer #(.V_PRELOAD('hFD8)) dut (
        .clk(clk), ._reset(_reset), .ce(ce), .start(start), .stop_req(stop_req),
        .hcount(hcount), .vcount(vcount), .h_rco(h_rco), .v_rco(v_rco),
        .hblank(hblank), .vblank(vblank), ._hsync(_hsync), ._vsync(_vsync),
        .frame_start(frame_start), .running(running), .stopped(stopped)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ce3(input int n);
        repeat (n) begin
            ce = 1'b1;
            tick(1);
            ce = 1'b0;
            tick(2);
        end
    endtask

    initial begin
        #1 _reset = 1'b0;
        #1;
        chk("rst_hcount", hcount, 'hE00);
        chk("rst_vcount", vcount, 'hFD8);
        chk("rst_stopped", stopped, 1);
        chk("rst_running", running, 0);
        chk("rst_hblank", hblank, 1);
        chk("rst_vblank", vblank, 1);
        chk("rst_hsync", _hsync, 1);
        chk("rst_vsync", _vsync, 1);
        chk("rst_hrco", h_rco, 0);
        tick(2);
        _reset = 1'b1;
        tick(100);
        chk("idle_hcount", hcount, 'hE00);
        chk("idle_vcount", vcount, 'hFD8);
        chk("idle_stopped", stopped, 1);
        chk("idle_hblank", hblank, 0);
        chk("idle_vblank", vblank, 0);
        chk("idle_hsync", _hsync, 1);
        chk("idle_frame_start", frame_start, 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("run_running", running, 1);
        chk("run_frame_start", frame_start, 1);
        chk("run_hcount0", hcount, 'hE00);
        tick(1);
        chk("first_inc", hcount, 'hE01);
        chk("fs_drop", frame_start, 0);
        tick(254);
        chk("h_EFF", hcount, 'hEFF);
        chk("hrco_EFF", h_rco, 0);
        tick(1);
        chk("hblank_at_F00", hblank, 0);
        tick(1);
        chk("hblank_after_F00", hblank, 1);
        chk("h_F01", hcount, 'hF01);
        tick(31);
        chk("hsync_at_F20", _hsync, 1);
        tick(1);
        chk("hsync_after_F20", _hsync, 0);
        tick(31);
        chk("hsync_at_F40", _hsync, 0);
        tick(1);
        chk("hsync_after_F40", _hsync, 1);
        tick(189);
        chk("hrco_FFE", h_rco, 0);
        tick(1);
        chk("h_FFF", hcount, 'hFFF);
        chk("hrco_FFF", h_rco, 1);
        chk("vrco_line", v_rco, 0);
        tick(1);
        chk("h_wrap", hcount, 'hE00);
        chk("v_inc", vcount, 'hFD9);
        chk("hrco_E00", h_rco, 0);
        chk("hblank_at_E00", hblank, 1);
        tick(1);
        chk("hblank_after_E00", hblank, 0);
        tick(3583);
        chk("v_FE0", vcount, 'hFE0);
        chk("vblank_at_FE0", vblank, 0);
        tick(1);
        chk("vblank_after_FE0", vblank, 1);
        tick(4095);
        chk("v_FE8", vcount, 'hFE8);
        chk("vsync_at_FE8", _vsync, 1);
        tick(1);
        chk("vsync_after_FE8", _vsync, 0);
        tick(2047);
        chk("v_FEC", vcount, 'hFEC);
        chk("vsync_at_FEC", _vsync, 0);
        tick(1);
        chk("vsync_after_FEC", _vsync, 1);
        tick(10237);
        chk("vrco_early", v_rco, 0);
        tick(1);
        chk("vrco_frame1", v_rco, 1);
        tick(1);
        chk("frame2_start", frame_start, 1);
        chk("frame2_v", vcount, 'hFD8);
        tick(20479);
        chk("vrco_frame2", v_rco, 1);
        tick(1);
        tick(100);
        stop_req = 1'b1;
        tick(1);
        stop_req = 1'b0;
        chk("stop_still_running", running, 1);
        chk("stop_h", hcount, 'hE65);
        tick(20378);
        chk("stop_vrco", v_rco, 1);
        chk("stop_running_at_end", running, 1);
        tick(1);
        chk("stop_running", running, 0);
        chk("stop_stopped", stopped, 1);
        chk("stop_h_pre", hcount, 'hE00);
        chk("stop_v_pre", vcount, 'hFD8);
        tick(5);
        chk("stop_hold_h", hcount, 'hE00);
        chk("stop_hold_st", stopped, 1);
        start = 1'b1;
        stop_req = 1'b1;
        tick(1);
        start = 1'b0;
        stop_req = 1'b0;
        chk("both_running", running, 1);
        ce3(1);
        chk("ce_first", hcount, 'hE01);
        ce3(510);
        chk("ce_FFF", hcount, 'hFFF);
        chk("ce_hrco_held", h_rco, 1);
        ce3(1);
        chk("ce_wrap_h", hcount, 'hE00);
        chk("ce_wrap_v", vcount, 'hFD9);
        ce = 1'b1;
        tick(19967);
        chk("nopend_vrco", v_rco, 1);
        tick(1);
        chk("nopend_running", running, 1);
        chk("nopend_v", vcount, 'hFD8);
        tick(311);
        chk("mid_h", hcount, 'hF37);
        chk("mid_hsync", _hsync, 0);
        #2 _reset = 1'b0;
        #1;
        chk("async_h", hcount, 'hE00);
        chk("async_v", vcount, 'hFD8);
        chk("async_running", running, 0);
        chk("async_hsync", _hsync, 1);
        chk("async_stopped", stopped, 1);
        #10 _reset = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
